// File: rtl/regfile_scoreboard.sv
// Register file: two combinational read ports, one write port, optional
// write-to-read bypass, and a busy scoreboard for read-after-write hazards.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [ADDR_W:0]   busy_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  busy_count_q, busy_count_d;

  logic w_ok, s_ok, ra_ok, rb_ok, fwd_a, fwd_b;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_ok  = we && addr_ok(waddr);
  assign s_ok  = issue_valid && addr_ok(issue_rd);
  assign ra_ok = addr_ok(raddr_a);
  assign rb_ok = addr_ok(raddr_b);
  assign fwd_a = (BYPASS != 0) && we && (waddr == raddr_a);
  assign fwd_b = (BYPASS != 0) && we && (waddr == raddr_b);

  always_comb begin
    mem_d = mem_q;
    if (w_ok) mem_d[waddr] = wdata;
  end

  // Clear first, then set: a new producer overrides a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    if (w_ok) busy_d[waddr] = 1'b0;
    if (s_ok) busy_d[issue_rd] = 1'b1;
  end

  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < DEPTH; i++)
      busy_count_d = busy_count_d + (ADDR_W+1)'(busy_d[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      mem_q        <= mem_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  always_comb begin
    rdata_a  = '0;
    hazard_a = 1'b0;
    if (ra_ok) begin
      rdata_a  = fwd_a ? wdata : mem_q[raddr_a];
      hazard_a = busy_q[raddr_a] && !fwd_a;
    end
  end

  always_comb begin
    rdata_b  = '0;
    hazard_b = 1'b0;
    if (rb_ok) begin
      rdata_b  = fwd_b ? wdata : mem_q[raddr_b];
      hazard_b = busy_q[raddr_b] && !fwd_b;
    end
  end

  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: four configurations share one stimulus
// stream and are checked against an array-based reference model.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [4:0]  ra = '0, rb = '0, wa = '0, ird = '0;
  logic        we = 1'b0, iv = 1'b0;
  logic [31:0] wd = '0;

  logic [31:0] rda [4];
  logic [31:0] rdb [4];
  logic        hza [4];
  logic        hzb [4];
  logic [5:0]  bc  [4];

  int checks = 0;
  int errors = 0;

  localparam int CD [4] = '{32, 32, 24, 20};
  localparam int CZ [4] = '{1, 1, 1, 0};
  localparam int CB [4] = '{1, 0, 1, 0};
  localparam int FILL [4] = '{31, 31, 23, 20};

  regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ADDR_W(5),
    .ZERO_REG(1), .BYPASS(1)) u0 (
    .clk(clk), .reset(reset), .raddr_a(ra), .raddr_b(rb),
    .rdata_a(rda[0]), .rdata_b(rdb[0]), .we(we), .waddr(wa),
    .wdata(wd), .issue_valid(iv), .issue_rd(ird),
    .hazard_a(hza[0]), .hazard_b(hzb[0]), .busy_count(bc[0]));

  regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ADDR_W(5),
    .ZERO_REG(1), .BYPASS(0)) u1 (
    .clk(clk), .reset(reset), .raddr_a(ra), .raddr_b(rb),
    .rdata_a(rda[1]), .rdata_b(rdb[1]), .we(we), .waddr(wa),
    .wdata(wd), .issue_valid(iv), .issue_rd(ird),
    .hazard_a(hza[1]), .hazard_b(hzb[1]), .busy_count(bc[1]));

  regfile_scoreboard #(.WIDTH(32), .DEPTH(24), .ADDR_W(5),
    .ZERO_REG(1), .BYPASS(1)) u2 (
    .clk(clk), .reset(reset), .raddr_a(ra), .raddr_b(rb),
    .rdata_a(rda[2]), .rdata_b(rdb[2]), .we(we), .waddr(wa),
    .wdata(wd), .issue_valid(iv), .issue_rd(ird),
    .hazard_a(hza[2]), .hazard_b(hzb[2]), .busy_count(bc[2]));

  regfile_scoreboard #(.WIDTH(32), .DEPTH(20), .ADDR_W(5),
    .ZERO_REG(0), .BYPASS(0)) u3 (
    .clk(clk), .reset(reset), .raddr_a(ra), .raddr_b(rb),
    .rdata_a(rda[3]), .rdata_b(rdb[3]), .we(we), .waddr(wa),
    .wdata(wd), .issue_valid(iv), .issue_rd(ird),
    .hazard_a(hza[3]), .hazard_b(hzb[3]), .busy_count(bc[3]));

  // Reference model: plain arrays, updated once per clock edge.
  logic [31:0] m_reg  [4][32];
  bit          m_busy [4][32];

  function automatic bit m_valid(int c, logic [4:0] a);
    return (int'(a) < CD[c]) && !(CZ[c] == 1 && a == 5'd0);
  endfunction

  function automatic bit m_fwd(int c, logic [4:0] a);
    return CB[c] == 1 && we && wa == a;
  endfunction

  function automatic logic [31:0] m_read(int c, logic [4:0] a);
    if (!m_valid(c, a)) return 32'd0;
    if (m_fwd(c, a)) return wd;
    return m_reg[c][a];
  endfunction

  function automatic bit m_haz(int c, logic [4:0] a);
    return m_valid(c, a) && m_busy[c][a] && !m_fwd(c, a);
  endfunction

  function automatic int m_cnt(int c);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[c][i]);
    return n;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 32; i++) begin
        m_reg[c][i]  = '0;
        m_busy[c][i] = 1'b0;
      end
  endtask

  task automatic m_update();
    for (int c = 0; c < 4; c++) begin
      if (we && m_valid(c, wa)) begin
        m_reg[c][wa]  = wd;
        m_busy[c][wa] = 1'b0;
      end
      if (iv && m_valid(c, ird)) m_busy[c][ird] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    iv = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #2;
    m_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    ra = 5'd5;
    rb = 5'd5;
    #3;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (rda[c] !== 32'd0 || hza[c] !== 1'b0 || bc[c] !== 6'd0) begin
        errors++;
        $display("FAIL reset_hold cfg%0d got rd=%h hz=%b bc=%0d want 0",
          c, rda[c], hza[c], bc[c]);
      end
    end
    @(posedge clk);
    #1;
    m_reset();
    reset = 1'b0;
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    iv = 1'b1; ird = 5'd5;
    tick();
    idle();
    #3;
    checks++;
    if (rda[0] !== 32'hDEADBEEF || bc[0] !== 6'd1) begin
      errors++;
      $display("FAIL reset_prewrite got rd=%h bc=%0d want deadbeef 1",
        rda[0], bc[0]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (rda[0] !== 32'd0 || bc[0] !== 6'd0 || hza[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got rd=%h bc=%0d hz=%b want 0 0 0",
        rda[0], bc[0], hza[0]);
    end
    m_reset();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_reg();
    do_reset();
    we = 1'b1; wa = 5'd0; wd = 32'h1234;
    iv = 1'b1; ird = 5'd0; ra = 5'd0;
    #3;
    checks++;
    if (rda[0] !== 32'd0 || hza[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_bypass got rd=%h hz=%b want 0 0", rda[0], hza[0]);
    end
    tick();
    idle();
    #3;
    checks++;
    if (rda[0] !== 32'd0 || bc[0] !== 6'd0) begin
      errors++;
      $display("FAIL zero_store got rd=%h bc=%0d want 0 0", rda[0], bc[0]);
    end
    checks++;
    if (rda[3] !== 32'h1234 || bc[3] !== 6'd1) begin
      errors++;
      $display("FAIL nozero_r0 got rd=%h bc=%0d want 1234 1", rda[3], bc[3]);
    end
    tick();
  endtask

  task automatic test_bypass();
    do_reset();
    we = 1'b1; wa = 5'd3; wd = 32'h11;
    tick();
    wd = 32'h22; ra = 5'd3; rb = 5'd3;
    #3;
    checks++;
    if (rda[0] !== 32'h22 || rdb[0] !== 32'h22) begin
      errors++;
      $display("FAIL bypass_on got a=%h b=%h want 22 22", rda[0], rdb[0]);
    end
    checks++;
    if (rda[1] !== 32'h11 || rdb[1] !== 32'h11) begin
      errors++;
      $display("FAIL bypass_off got a=%h b=%h want 11 11", rda[1], rdb[1]);
    end
    tick();
    idle();
    #3;
    checks++;
    if (rda[1] !== 32'h22 || rdb[1] !== 32'h22) begin
      errors++;
      $display("FAIL bypass_off_next got a=%h b=%h want 22 22",
        rda[1], rdb[1]);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    do_reset();
    iv = 1'b1; ird = 5'd7;
    tick();
    idle();
    ra = 5'd7;
    #3;
    checks++;
    if (hza[0] !== 1'b1 || bc[0] !== 6'd1) begin
      errors++;
      $display("FAIL sb_issue got hz=%b bc=%0d want 1 1", hza[0], bc[0]);
    end
    we = 1'b1; wa = 5'd7; wd = 32'h77;
    #1;
    checks++;
    if (hza[0] !== 1'b0 || hza[1] !== 1'b1) begin
      errors++;
      $display("FAIL sb_wb_hazard got byp=%b nobyp=%b want 0 1",
        hza[0], hza[1]);
    end
    tick();
    idle();
    #3;
    checks++;
    if (bc[0] !== 6'd0 || hza[1] !== 1'b0 || rda[1] !== 32'h77) begin
      errors++;
      $display("FAIL sb_clear got bc=%0d hz=%b rd=%h want 0 0 77",
        bc[0], hza[1], rda[1]);
    end
    tick();
  endtask

  task automatic test_set_clr();
    do_reset();
    iv = 1'b1; ird = 5'd9;
    tick();
    we = 1'b1; wa = 5'd9; wd = 32'hCAFE0009;
    tick();
    idle();
    ra = 5'd9;
    #3;
    checks++;
    if (bc[0] !== 6'd1 || hza[0] !== 1'b1 || rda[0] !== 32'hCAFE0009) begin
      errors++;
      $display("FAIL set_clr got bc=%0d hz=%b rd=%h want 1 1 cafe0009",
        bc[0], hza[0], rda[0]);
    end
    tick();
  endtask

  task automatic test_range_fill();
    do_reset();
    we = 1'b1; wa = 5'd28; wd = 32'hA5A5A5A5;
    iv = 1'b1; ird = 5'd28; ra = 5'd28;
    #3;
    checks++;
    if (rda[2] !== 32'd0 || hza[2] !== 1'b0 || rda[0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL range_bypass got d24=%h hz=%b d32=%h want 0 0 a5a5a5a5",
        rda[2], hza[2], rda[0]);
    end
    tick();
    idle();
    #3;
    checks++;
    if (rda[2] !== 32'd0 || bc[2] !== 6'd0) begin
      errors++;
      $display("FAIL range_ignore got rd=%h bc=%0d want 0 0", rda[2], bc[2]);
    end
    checks++;
    if (rda[0] !== 32'hA5A5A5A5 || bc[0] !== 6'd1 || hza[0] !== 1'b1) begin
      errors++;
      $display("FAIL range_inrange got rd=%h bc=%0d hz=%b want a5a5a5a5 1 1",
        rda[0], bc[0], hza[0]);
    end
    for (int a = 0; a < 32; a++) begin
      iv = 1'b1;
      ird = 5'(a);
      tick();
    end
    idle();
    #3;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bc[c] !== 6'(FILL[c])) begin
        errors++;
        $display("FAIL fill_count cfg%0d got %0d want %0d",
          c, bc[c], FILL[c]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      wa  = 5'($urandom_range(0, 31));
      ird = 5'($urandom_range(0, 31));
      ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      we  = 1'($urandom_range(0, 1));
      iv  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      #3;
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (rda[c] !== m_read(c, ra) || rdb[c] !== m_read(c, rb)) begin
          errors++;
          $display("FAIL rand_rdata cfg%0d n=%0d got %h/%h want %h/%h",
            c, n, rda[c], rdb[c], m_read(c, ra), m_read(c, rb));
        end
        checks++;
        if (hza[c] !== m_haz(c, ra) || hzb[c] !== m_haz(c, rb)) begin
          errors++;
          $display("FAIL rand_hazard cfg%0d n=%0d got %b/%b want %b/%b",
            c, n, hza[c], hzb[c], m_haz(c, ra), m_haz(c, rb));
        end
        checks++;
        if (int'(bc[c]) != m_cnt(c)) begin
          errors++;
          $display("FAIL rand_count cfg%0d n=%0d got %0d want %0d",
            c, n, bc[c], m_cnt(c));
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_set_clr();
    test_range_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-port data register storage.
- Provides DEPTH x WIDTH registers with two independent read ports, one write port, and an optional hardwired-zero register 0.
- Adds optional write-to-read bypass and a per-register busy scoreboard, so the RISC-V decode stage can detect read-after-write hazards.
- Sits between decode (read and issue) and writeback (write and clear).

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers, 2..32.
- ADDR_W, 5, address bits; must satisfy 2**ADDR_W >= DEPTH.
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes and issues.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching reads.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- raddr_a  input  ADDR_W  read port A address.
- raddr_b  input  ADDR_W  read port B address.
- rdata_a  output  WIDTH  read data A (combinational).
- rdata_b  output  WIDTH  read data B (combinational).
- we  input  1  write/writeback enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- issue_valid  input  1  an instruction producing issue_rd is issued this cycle.
- issue_rd  input  ADDR_W  destination register of the issued instruction.
- hazard_a  output  1  register at raddr_a has a pending, unforwarded write.
- hazard_b  output  1  register at raddr_b has a pending, unforwarded write.
- busy_count  output  ADDR_W+1  number of registers currently marked busy.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset value: all registers 0, all busy bits 0, busy_count 0. With every register at 0, rdata_a/b read 0 and hazard_a/b are 0 during and after reset.
- Reset asserted mid-operation: clears everything at once, regardless of any we or issue_valid in flight. Pending writes are lost.
- Valid address: addr < DEPTH, and not (ZERO_REG and addr==0).
  - Reads of an out-of-range address return 0 with hazard 0.
  - Writes and issues to an invalid address are ignored.
- Read port X (evaluated per port, same rules for A and B), in priority order:
  - ZERO_REG and raddr==0: returns 0.
  - Out of range: returns 0.
  - BYPASS and we and waddr==raddr and write valid: returns wdata.
  - Otherwise: returns the stored register.
  - Read latency: 0 cycles. Without bypass, a write is visible 1 cycle after the clock edge.
- Write: at posedge clk, if we and the write address is valid, then reg[waddr] <= wdata.
- Scoreboard, applied at posedge clk per register r:
  - set = issue_valid and issue_rd==r and r valid.
  - clr = we and waddr==r and r valid.
  - set and clr on the same r in the same cycle: set wins, busy stays 1 (a new producer overrides).
  - Otherwise: set gives 1, clr gives 0, neither holds the previous value.
  - A second issue to an already-busy register keeps it busy. There is no per-register count: writeback is in-order and the first writeback clears the bit.
  - clr on a non-busy register is legal and has no effect.
- hazard_X = busy[raddr_X] and not (BYPASS and we and waddr==raddr_X). Combinational.
- busy_count: registered population count of busy bits. It always equals the number of set busy bits after each edge and never exceeds DEPTH.

Test Plan:
- Reset clears state: write 0xDEADBEEF to r5, then assert reset asynchronously between edges -> rdata_a for r5 drops to 0 before the next edge; busy_count=0.
- Zero register: ZERO_REG=1; we=1, waddr=0, wdata=0x1234; issue to rd 0 -> rdata_a(0)=0, hazard_a=0, busy_count unchanged.
- Dual read with bypass: r3=0x11; in the same cycle we r3=0x22, raddr_a=3, raddr_b=3 -> both ports read 0x22 that cycle. With BYPASS=0, both read 0x11 that cycle and 0x22 on the next.
- Scoreboard flow: issue rd=7 -> next cycle hazard_a=1 (raddr_a=7), busy_count=1. Writeback r7 with BYPASS=1 -> hazard_a=0 in that same cycle; the following cycle busy_count=0.
- Simultaneous set and clear: r9 busy; issue rd=9 and we waddr=9 in the same cycle -> r9 remains busy, busy_count stays 1, stored value = new wdata.
- Range and fill: DEPTH=24; write and issue to addr 28 -> ignored, reads of 28 return 0. Issue all 23 valid non-zero registers -> busy_count=23.
